// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT control FSM.
// Drives datapath strobes and mux selects for a RV32I-style multicycle core,
// with a memory wait watchdog that parks the machine in HALT on timeout.
module multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       target_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       retire,
  output logic       halted,
  output logic       fault,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [1:0] alu_mode,
  output logic [1:0] wb_sel,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [15:0] LIMIT = 16'(WAIT_LIMIT);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_wait;
  logic        r_fault;
  logic        w_fault_set;
  logic        w_legal;
  logic        w_wait_hit;

  // Legal opcode decode.
  always_comb begin
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: w_legal = 1'b1;
      default:                                      w_legal = 1'b0;
    endcase
  end

  // This wait cycle is the one that brings the counter up to the limit.
  assign w_wait_hit = (LIMIT != 16'd0) && !mem_ready && ((r_wait + 16'd1) == LIMIT);

  // Next-state and output decode; everything is forced idle while reset is high.
  always_comb begin
    w_next       = r_state;
    w_fault_set  = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    ir_write     = 1'b0;
    target_write = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    reg_write    = 1'b0;
    retire       = 1'b0;
    halted       = 1'b0;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 2'd0;
    alu_mode     = 2'd0;
    wb_sel       = 2'd0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_b_sel = 2'd2;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            w_next   = S_DECODE;
          end else if (w_wait_hit) begin
            w_next      = S_HALT;
            w_fault_set = 1'b1;
          end
        end
        S_DECODE: begin
          alu_a_sel    = 2'd1;
          alu_b_sel    = 2'd1;
          target_write = 1'b1;
          if (w_legal) begin
            w_next = S_EXEC;
          end else begin
            w_next      = S_HALT;
            w_fault_set = 1'b1;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_R:      begin alu_a_sel = 2'd2; alu_mode = 2'd1; w_next = S_WB; end
            OP_I:      begin alu_a_sel = 2'd2; alu_b_sel = 2'd1; alu_mode = 2'd1; w_next = S_WB; end
            OP_LOAD,
            OP_STORE:  begin alu_a_sel = 2'd2; alu_b_sel = 2'd1; w_next = S_MEM; end
            OP_BRANCH: begin
              alu_a_sel = 2'd2;
              alu_mode  = 2'd2;
              pc_src    = 1'b1;
              pc_write  = branch_taken;
              retire    = 1'b1;
              w_next    = S_FETCH;
            end
            OP_JAL: begin
              pc_src    = 1'b1;
              pc_write  = 1'b1;
              reg_write = 1'b1;
              wb_sel    = 2'd2;
              retire    = 1'b1;
              w_next    = S_FETCH;
            end
            // rd is written with the old PC on the same edge that loads the new one.
            OP_JALR: begin
              alu_a_sel = 2'd2;
              alu_b_sel = 2'd1;
              pc_write  = 1'b1;
              reg_write = 1'b1;
              wb_sel    = 2'd2;
              retire    = 1'b1;
              w_next    = S_FETCH;
            end
            OP_LUI:    begin alu_a_sel = 2'd3; alu_b_sel = 2'd1; w_next = S_WB; end
            OP_AUIPC:  begin alu_a_sel = 2'd1; alu_b_sel = 2'd1; w_next = S_WB; end
            OP_SYSTEM: begin retire = 1'b1; halted = 1'b1; w_next = S_HALT; end
            default:   begin w_next = S_HALT; w_fault_set = 1'b1; end
          endcase
        end
        S_MEM: begin
          alu_a_sel = 2'd2;
          alu_b_sel = 2'd1;
          iord      = 1'b1;
          if (opcode == OP_LOAD) mem_read  = 1'b1;
          else                   mem_write = 1'b1;
          if (mem_ready) begin
            if (opcode == OP_LOAD) begin
              w_next = S_WB;
            end else begin
              retire = 1'b1;
              w_next = S_FETCH;
            end
          end else if (w_wait_hit) begin
            w_next      = S_HALT;
            w_fault_set = 1'b1;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          wb_sel    = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
          w_next    = S_FETCH;
        end
        S_HALT: halted = 1'b1;
        // Unused encodings are treated as corruption.
        default: begin
          w_next      = S_HALT;
          w_fault_set = 1'b1;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Sticky fault flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_fault <= 1'b0;
    else if (w_fault_set) r_fault <= 1'b1;
  end

  // Consecutive wait counter: cleared on every state change, counts stalls in FETCH/MEM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_wait <= 16'd0;
    else if (w_next != r_state)
      r_wait <= 16'd0;
    else if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ready && r_wait != 16'hFFFF)
      r_wait <= r_wait + 16'd1;
  end

  assign fault = r_fault;
  assign state = r_state;

endmodule
